// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the memory-port arbiter: FSM states, bus SIZE codes
// and the default fetch-starvation tolerance.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DROP   = 2'd3
  } arb_state_e;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

  // Pick the 32-bit instruction word out of a 64-bit bus beat.
  function automatic logic [31:0] word_select(input logic [63:0] dword, input logic upper);
    return upper ? dword[63:32] : dword[31:0];
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction-fetch and data load/store ports onto one shared
// memory port: data has priority, bounded by a fetch-starvation counter.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FLUSH,
  input  logic        IF_REQ,
  input  logic [63:0] IF_ADDR,
  output logic        IF_ACK,
  output logic [31:0] IF_RDATA,
  input  logic        D_REQ,
  input  logic        D_WE,
  input  logic [1:0]  D_SIZE,
  input  logic [63:0] D_ADDR,
  input  logic [63:0] D_WDATA,
  output logic        D_ACK,
  output logic [63:0] D_RDATA,
  output logic        BUS_REQ,
  output logic        BUS_WE,
  output logic [1:0]  BUS_SIZE,
  output logic [63:0] BUS_ADDR,
  output logic [63:0] BUS_WDATA,
  input  logic        BUS_RDY,
  input  logic [63:0] BUS_RDATA
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  arb_state_e       state;
  logic [CNT_W-1:0] starve_cnt;
  logic             if_pend;
  logic             d_pend;
  logic             pick_fetch;

  // A requester is not re-granted in its own ACK cycle; FLUSH hides fetches.
  assign if_pend    = IF_REQ && !IF_ACK && !FLUSH;
  assign d_pend     = D_REQ && !D_ACK;
  assign pick_fetch = if_pend && (!d_pend || (starve_cnt == LIMIT_C));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      starve_cnt <= '0;
      IF_ACK     <= 1'b0;
      IF_RDATA   <= '0;
      D_ACK      <= 1'b0;
      D_RDATA    <= '0;
      BUS_REQ    <= 1'b0;
      BUS_WE     <= 1'b0;
      BUS_SIZE   <= '0;
      BUS_ADDR   <= '0;
      BUS_WDATA  <= '0;
    end else begin
      IF_ACK <= 1'b0;
      D_ACK  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_fetch) begin
            state      <= BUSY_I;
            BUS_REQ    <= 1'b1;
            BUS_WE     <= 1'b0;
            BUS_SIZE   <= SIZE_W;
            BUS_ADDR   <= IF_ADDR;
            BUS_WDATA  <= '0;
            starve_cnt <= '0;
          end else if (d_pend) begin
            state     <= BUSY_D;
            BUS_REQ   <= 1'b1;
            BUS_WE    <= D_WE;
            BUS_SIZE  <= D_SIZE;
            BUS_ADDR  <= D_ADDR;
            BUS_WDATA <= D_WDATA;
            // Raw IF_REQ: a fetch hidden by FLUSH still counts as waiting.
            if (!IF_REQ)
              starve_cnt <= '0;
            else if (starve_cnt != LIMIT_C)
              starve_cnt <= starve_cnt + CNT_W'(1);
          end
        end
        BUSY_I: begin
          if (BUS_RDY) begin
            state   <= IDLE;
            BUS_REQ <= 1'b0;
            if (!FLUSH) begin
              IF_ACK   <= 1'b1;
              IF_RDATA <= word_select(BUS_RDATA, BUS_ADDR[2]);
            end
          end else if (FLUSH) begin
            state <= DROP;
          end
        end
        BUSY_D: begin
          if (BUS_RDY) begin
            state   <= IDLE;
            BUS_REQ <= 1'b0;
            D_ACK   <= 1'b1;
            D_RDATA <= BUS_RDATA;
          end
        end
        DROP: begin
          if (BUS_RDY) begin
            state   <= IDLE;
            BUS_REQ <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed corner cases then random
// traffic, checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        CLK = 1'b0;
  logic        RESET, FLUSH;
  logic        IF_REQ;
  logic [63:0] IF_ADDR;
  logic        IF_ACK;
  logic [31:0] IF_RDATA;
  logic        D_REQ, D_WE;
  logic [1:0]  D_SIZE;
  logic [63:0] D_ADDR, D_WDATA;
  logic        D_ACK;
  logic [63:0] D_RDATA;
  logic        BUS_REQ, BUS_WE;
  logic [1:0]  BUS_SIZE;
  logic [63:0] BUS_ADDR, BUS_WDATA;
  logic        BUS_RDY;
  logic [63:0] BUS_RDATA;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_ACK(IF_ACK), .IF_RDATA(IF_RDATA),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_SIZE(D_SIZE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_ACK(D_ACK), .D_RDATA(D_RDATA),
    .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE), .BUS_SIZE(BUS_SIZE), .BUS_ADDR(BUS_ADDR),
    .BUS_WDATA(BUS_WDATA), .BUS_RDY(BUS_RDY), .BUS_RDATA(BUS_RDATA)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned due;
    bit          is_fetch;
    logic        we;
    logic [1:0]  size;
    logic [63:0] addr;
    logic [63:0] wdata;
  } cmd_t;

  typedef struct {
    int unsigned due;
    logic [63:0] data;
  } ack_t;

  cmd_t bus_q[$];
  ack_t if_q[$];
  ack_t d_q[$];

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: who owns the bus (0 none, 1 fetch, 2 data, 3 cancelled
  // fetch), how many data grants a waiting fetch has seen, and this cycle's acks.
  int unsigned m_owner = 0;
  int unsigned m_cnt = 0;
  bit          m_if_ack = 0, m_d_ack = 0, m_sel = 0;
  bit          rst_chk = 0;
  logic [63:0] hold_if = '0, hold_d = '0;

  always @(posedge CLK) begin
    bit want_if, want_d, na_if, na_d;
    cmd_t c;
    ack_t a;
    cyc++;
    na_if = 0;
    na_d  = 0;
    if (RESET) begin
      m_owner = 0;
      m_cnt   = 0;
      bus_q.delete();
      if_q.delete();
      d_q.delete();
      rst_chk = 1;
      hold_if = '0;
      hold_d  = '0;
    end else begin
      case (m_owner)
        0: begin
          want_if = IF_REQ && !m_if_ack && !FLUSH;
          want_d  = D_REQ && !m_d_ack;
          if (want_if && (!want_d || m_cnt == LIMIT)) begin
            c.due = cyc; c.is_fetch = 1; c.we = 1'b0; c.size = 2'b10;
            c.addr = IF_ADDR; c.wdata = '0;
            bus_q.push_back(c);
            m_sel   = IF_ADDR[2];
            m_cnt   = 0;
            m_owner = 1;
          end else if (want_d) begin
            c.due = cyc; c.is_fetch = 0; c.we = D_WE; c.size = D_SIZE;
            c.addr = D_ADDR; c.wdata = D_WDATA;
            bus_q.push_back(c);
            m_cnt   = IF_REQ ? ((m_cnt < LIMIT) ? m_cnt + 1 : LIMIT) : 0;
            m_owner = 2;
          end
        end
        1: begin
          if (BUS_RDY) begin
            if (!FLUSH) begin
              a.due  = cyc;
              a.data = (BUS_RDATA >> (m_sel ? 32 : 0)) & 64'h0000_0000_FFFF_FFFF;
              if_q.push_back(a);
              na_if = 1;
            end
            m_owner = 0;
          end else if (FLUSH) begin
            m_owner = 3;
          end
        end
        2: begin
          if (BUS_RDY) begin
            a.due  = cyc;
            a.data = BUS_RDATA;
            d_q.push_back(a);
            na_d    = 1;
            m_owner = 0;
          end
        end
        default: if (BUS_RDY) m_owner = 0;
      endcase
    end
    m_if_ack = na_if;
    m_d_ack  = na_d;
  end

  // Monitor: pops expectations when the DUT presents a command or an ACK.
  bit   prev_bus_req = 0;
  cmd_t cur;

  always @(negedge CLK) begin
    ack_t a;
    if (rst_chk) begin
      rst_chk = 0;
      check("reset_outputs_zero",
            {63'h0, |{IF_ACK, IF_RDATA, D_ACK, D_RDATA, BUS_REQ, BUS_WE, BUS_SIZE, BUS_ADDR, BUS_WDATA}},
            64'h0);
    end
    while (bus_q.size() > 0 && bus_q[0].due < cyc) begin
      check("bus_grant_missing", 64'h0, 64'h1);
      void'(bus_q.pop_front());
    end
    if (BUS_REQ && !prev_bus_req) begin
      if (bus_q.size() == 0) begin
        check("bus_grant_unexpected", {63'h0, BUS_REQ}, 64'h0);
      end else begin
        cur = bus_q.pop_front();
        check("bus_grant_cycle", 64'(cyc), 64'(cur.due));
        check("bus_addr", BUS_ADDR, cur.addr);
        check("bus_we", {63'h0, BUS_WE}, {63'h0, cur.we});
        check("bus_size", {62'h0, BUS_SIZE}, {62'h0, cur.size});
        if (!cur.is_fetch) check("bus_wdata", BUS_WDATA, cur.wdata);
      end
    end else if (BUS_REQ) begin
      check("bus_cmd_hold", {BUS_ADDR[60:0], BUS_WE, BUS_SIZE}, {cur.addr[60:0], cur.we, cur.size});
    end
    prev_bus_req = BUS_REQ;

    while (if_q.size() > 0 && if_q[0].due < cyc) begin
      check("if_ack_missing", 64'h0, 64'h1);
      void'(if_q.pop_front());
    end
    if (IF_ACK) begin
      if (if_q.size() == 0 || if_q[0].due != cyc) begin
        check("if_ack_unexpected", {63'h0, IF_ACK}, 64'h0);
      end else begin
        a = if_q.pop_front();
        check("if_rdata", {32'h0, IF_RDATA}, a.data);
        hold_if = a.data;
      end
    end else begin
      check("if_rdata_hold", {32'h0, IF_RDATA}, hold_if);
    end

    while (d_q.size() > 0 && d_q[0].due < cyc) begin
      check("d_ack_missing", 64'h0, 64'h1);
      void'(d_q.pop_front());
    end
    if (D_ACK) begin
      if (d_q.size() == 0 || d_q[0].due != cyc) begin
        check("d_ack_unexpected", {63'h0, D_ACK}, 64'h0);
      end else begin
        a = d_q.pop_front();
        check("d_rdata", D_RDATA, a.data);
        hold_d = a.data;
      end
    end else begin
      check("d_rdata_hold", D_RDATA, hold_d);
    end
  end

  // Memory responder and requester release, applied once per cycle.
  int unsigned mem_lat = 0, busy_cnt = 0;
  bit          spur_en = 0, rand_lat = 0;

  task automatic cycle_common();
    @(negedge CLK);
    #1;
    if (IF_ACK) IF_REQ = 1'b0;
    if (D_ACK) D_REQ = 1'b0;
    BUS_RDATA = {$urandom, $urandom};
    if (BUS_REQ) begin
      if (busy_cnt == 0 && rand_lat) mem_lat = $urandom_range(0, 3);
      BUS_RDY  = (busy_cnt >= mem_lat);
      busy_cnt = BUS_RDY ? 0 : busy_cnt + 1;
    end else begin
      BUS_RDY  = spur_en && ($urandom_range(0, 7) == 0);
      busy_cnt = 0;
    end
  endtask

  task automatic wait_bus_req(input string name);
    int unsigned k = 0;
    while (!BUS_REQ && k < 10) begin
      cycle_common();
      k++;
    end
    check(name, {63'h0, BUS_REQ}, 64'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n_if, n_d, k, flush_left;
    logic [63:0] rdy_data;

    RESET = 1'b1; FLUSH = 1'b0;
    IF_REQ = 1'b0; IF_ADDR = '0;
    D_REQ = 1'b0; D_WE = 1'b0; D_SIZE = '0; D_ADDR = '0; D_WDATA = '0;
    BUS_RDY = 1'b0; BUS_RDATA = '0;
    repeat (3) cycle_common();
    RESET = 1'b0;

    // Single fetch, memory ready at once, upper word selected.
    IF_REQ = 1'b1; IF_ADDR = 64'h1004;
    cycle_common();
    BUS_RDATA = 64'hAAAA_BBBB_CCCC_DDDD;
    check("t031_bus_req", {63'h0, BUS_REQ}, 64'h1);
    check("t031_bus_addr", BUS_ADDR, 64'h1004);
    check("t031_bus_size", {62'h0, BUS_SIZE}, 64'h2);
    cycle_common();
    check("t031_if_ack", {63'h0, IF_ACK}, 64'h1);
    check("t031_if_rdata", {32'h0, IF_RDATA}, 64'hAAAA_BBBB);

    // Simultaneous fetch and store: data first, each acked once.
    cycle_common();
    IF_REQ = 1'b1; IF_ADDR = 64'h3000;
    D_REQ = 1'b1; D_WE = 1'b1; D_SIZE = 2'b11; D_ADDR = 64'h2000; D_WDATA = 64'h0123_4567_89AB_CDEF;
    cycle_common();
    check("t032_first_bus_we", {63'h0, BUS_WE}, 64'h1);
    check("t032_first_bus_addr", BUS_ADDR, 64'h2000);
    n_if = 0; n_d = 0;
    repeat (20) begin
      cycle_common();
      if (IF_ACK) n_if++;
      if (D_ACK) n_d++;
    end
    check("t032_if_ack_count", 64'(n_if), 64'h1);
    check("t032_d_ack_count", 64'(n_d), 64'h1);

    // Flush during a slow fetch: dropped, bus handshake still completes.
    mem_lat = 3; IF_REQ = 1'b1; IF_ADDR = 64'h4008;
    wait_bus_req("t034_fetch_granted");
    FLUSH = 1'b1;
    cycle_common();
    FLUSH = 1'b0; IF_REQ = 1'b0;
    check("t034_drop_bus_req", {63'h0, BUS_REQ}, 64'h1);
    n_if = 0; k = 0;
    while (BUS_REQ && k < 10) begin
      cycle_common();
      if (IF_ACK) n_if++;
      k++;
    end
    repeat (2) begin
      cycle_common();
      if (IF_ACK) n_if++;
    end
    check("t034_bus_released", {63'h0, BUS_REQ}, 64'h0);
    check("t034_no_if_ack", 64'(n_if), 64'h0);
    mem_lat = 0; IF_REQ = 1'b1; IF_ADDR = 64'h4010;
    n_if = 0; k = 0;
    while (n_if == 0 && k < 10) begin
      cycle_common();
      if (IF_ACK) n_if++;
      k++;
    end
    check("t034_next_fetch_acked", 64'(n_if), 64'h1);

    // Flush during a load has no effect on it.
    mem_lat = 2; D_REQ = 1'b1; D_WE = 1'b0; D_SIZE = 2'b11; D_ADDR = 64'h5000;
    wait_bus_req("t036_load_granted");
    FLUSH = 1'b1;
    rdy_data = '0; n_d = 0; k = 0;
    while (n_d == 0 && k < 10) begin
      cycle_common();
      FLUSH = 1'b0;
      if (D_ACK) begin
        n_d++;
        check("t036_d_rdata", D_RDATA, rdy_data);
      end
      if (BUS_RDY && BUS_REQ) rdy_data = BUS_RDATA;
      k++;
    end
    check("t036_d_ack_seen", 64'(n_d), 64'h1);

    // Reset mid-store: outputs clear, a late BUS_RDY produces no ACK.
    mem_lat = 5; D_REQ = 1'b1; D_WE = 1'b1; D_SIZE = 2'b01; D_ADDR = 64'h6000; D_WDATA = 64'h55;
    wait_bus_req("t035_store_granted");
    RESET = 1'b1; D_REQ = 1'b0;
    cycle_common();
    RESET = 1'b0;
    check("t035_outputs_zero",
          {63'h0, |{IF_ACK, IF_RDATA, D_ACK, D_RDATA, BUS_REQ, BUS_WE, BUS_SIZE, BUS_ADDR, BUS_WDATA}}, 64'h0);
    n_d = 0;
    repeat (2) begin
      cycle_common();
      BUS_RDY = 1'b1;
      if (D_ACK) n_d++;
    end
    repeat (3) begin
      cycle_common();
      if (D_ACK) n_d++;
    end
    check("t035_no_d_ack", 64'(n_d), 64'h0);

    // Random traffic with flush bursts, spurious BUS_RDY and rare resets.
    spur_en = 1; rand_lat = 1; flush_left = 0;
    repeat (3000) begin
      cycle_common();
      if (RESET) begin
        RESET = 1'b0;
      end else if ($urandom_range(0, 399) == 0) begin
        RESET = 1'b1; IF_REQ = 1'b0; D_REQ = 1'b0; FLUSH = 1'b0; flush_left = 0;
      end
      if (!RESET) begin
        if (flush_left > 0) begin
          FLUSH = 1'b1;
          flush_left--;
        end else begin
          FLUSH = 1'b0;
          if ($urandom_range(0, 14) == 0) flush_left = $urandom_range(1, 16);
        end
        if (!IF_REQ && $urandom_range(0, 2) == 0) begin
          IF_REQ = 1'b1;
          IF_ADDR = {$urandom, $urandom} & ~64'h3;
        end
        if (!D_REQ && $urandom_range(0, 2) == 0) begin
          D_REQ = 1'b1;
          D_WE = 1'($urandom_range(0, 1));
          D_SIZE = 2'($urandom_range(0, 3));
          D_ADDR = {$urandom, $urandom};
          D_WDATA = {$urandom, $urandom};
        end
      end
    end

    FLUSH = 1'b0; RESET = 1'b0;
    repeat (40) cycle_common();
    check("drain_fetch_served", {63'h0, IF_REQ}, 64'h0);
    check("drain_data_served", {63'h0, D_REQ}, 64'h0);
    check("drain_bus_q", 64'(bus_q.size()), 64'h0);
    check("drain_if_q", 64'(if_q.size()), 64'h0);
    check("drain_d_q", 64'(d_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
